// File: rtl/useq_dispatch.sv
// useq_dispatch: microprogram sequencer owning the uPC register.
// Each cycle the current microword's seq_op steps the uPC (increment,
// opcode dispatch, return to fetch, hold). Dispatch decodes the opcode
// class into a microcode entry address and flags illegal opcodes.
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   instr_valid    opcode on 'opcode' is valid
//   instr_ready    combinational: opcode is consumed this cycle
//   opcode         instruction opcode field (7 bits)
//   seq_op         00 INC, 01 DISPATCH, 10 FETCH, 11 HOLD
//   stall          freezes the whole sequencer
//   clr_ill        clears the sticky illegal flag
//   upc            current microprogram counter (registered)
//   dispatch_fire  one-cycle pulse after each accepted dispatch
//   illegal        sticky: an illegal opcode was dispatched
//   icount         retired-instruction count, bumped by FETCH
module useq_dispatch #(
    parameter int unsigned UPC_W      = 5,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned FETCH_ADDR = 0,
    parameter int unsigned R_ADDR     = 3,
    parameter int unsigned I_ADDR     = 6,
    parameter int unsigned LD_ADDR    = 9,
    parameter int unsigned ST_ADDR    = 12,
    parameter int unsigned ILL_ADDR   = (32'd1 << UPC_W) - 32'd1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [6:0]       opcode,
    input  logic [1:0]       seq_op,
    input  logic             stall,
    input  logic             clr_ill,
    output logic [UPC_W-1:0] upc,
    output logic             dispatch_fire,
    output logic             illegal,
    output logic [CNT_W-1:0] icount
);

    localparam int unsigned DEPTH = 32'd1 << UPC_W;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    typedef enum logic [1:0] {
        SEQ_INC      = 2'b00,
        SEQ_DISPATCH = 2'b01,
        SEQ_FETCH    = 2'b10,
        SEQ_HOLD     = 2'b11
    } seq_op_e;

    // Every table entry must address a real ROM word.
    if (FETCH_ADDR >= DEPTH || R_ADDR >= DEPTH || I_ADDR >= DEPTH ||
        LD_ADDR >= DEPTH || ST_ADDR >= DEPTH || ILL_ADDR >= DEPTH) begin : g_addr_range_chk
        $error("useq_dispatch: address parameter does not fit in UPC_W bits");
    end

    logic [UPC_W-1:0] upc_n;
    logic             fire_n;
    logic             ill_n;
    logic [CNT_W-1:0] icount_n;
    logic [UPC_W-1:0] disp_addr;
    logic             op_legal;
    logic             accept;

    // Opcode class decode into microcode entry point.
    always_comb begin
        op_legal  = 1'b1;
        disp_addr = UPC_W'(ILL_ADDR);
        case (opcode)
            OP_R:    disp_addr = UPC_W'(R_ADDR);
            OP_I:    disp_addr = UPC_W'(I_ADDR);
            OP_LD:   disp_addr = UPC_W'(LD_ADDR);
            OP_ST:   disp_addr = UPC_W'(ST_ADDR);
            default: op_legal  = 1'b0;
        endcase
    end

    // Ready is offered whenever the microword asks for a dispatch, independent of valid.
    assign instr_ready = (seq_op == SEQ_DISPATCH) && !stall;
    assign accept      = instr_ready && instr_valid;

    // Next-state: stall freezes everything, including the illegal-flag clear.
    always_comb begin
        upc_n    = upc;
        fire_n   = 1'b0;
        ill_n    = illegal;
        icount_n = icount;
        if (!stall) begin
            if (clr_ill) begin
                ill_n = 1'b0;
            end
            case (seq_op)
                SEQ_INC: begin
                    upc_n = upc + UPC_W'(1);
                end
                SEQ_DISPATCH: begin
                    if (accept) begin
                        upc_n  = disp_addr;
                        fire_n = 1'b1;
                        // Setting wins over a coincident clear.
                        if (!op_legal) begin
                            ill_n = 1'b1;
                        end
                    end
                end
                SEQ_FETCH: begin
                    upc_n    = UPC_W'(FETCH_ADDR);
                    icount_n = icount + CNT_W'(1);
                end
                SEQ_HOLD: begin
                    upc_n = upc;
                end
                default: begin
                    upc_n = upc;
                end
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upc           <= UPC_W'(FETCH_ADDR);
            dispatch_fire <= 1'b0;
            illegal       <= 1'b0;
            icount        <= '0;
        end else begin
            upc           <= upc_n;
            dispatch_fire <= fire_n;
            illegal       <= ill_n;
            icount        <= icount_n;
        end
    end

endmodule

// File: tb/tb_useq_dispatch.sv
// Self-checking bench for useq_dispatch: directed scenarios plus random
// stimulus, checked every cycle against a behavioural model. A second
// instance with a 4-bit retired counter shares the stimulus.
module tb_useq_dispatch;

    localparam logic [1:0] INC = 2'b00;
    localparam logic [1:0] DSP = 2'b01;
    localparam logic [1:0] FET = 2'b10;
    localparam logic [1:0] HLD = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic [1:0]  seq_op = HLD;
    logic        stall = 1'b0;
    logic        clr_ill = 1'b0;

    logic        ready_a, fire_a, ill_a;
    logic [4:0]  upc_a;
    logic [15:0] icnt_a;
    logic        ready_b, fire_b, ill_b;
    logic [4:0]  upc_b;
    logic [3:0]  icnt_b;

    int compared = 0;
    int mismatched = 0;
    logic rdy_seen;

    // Behavioural model state
    int m_upc = 0;
    bit m_fire = 0;
    bit m_ill = 0;
    int m_cnt = 0;

    always #5 clk = ~clk;

    useq_dispatch u_a (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(ready_a),
        .opcode(opcode), .seq_op(seq_op), .stall(stall), .clr_ill(clr_ill),
        .upc(upc_a), .dispatch_fire(fire_a), .illegal(ill_a), .icount(icnt_a)
    );

    useq_dispatch #(.CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(ready_b),
        .opcode(opcode), .seq_op(seq_op), .stall(stall), .clr_ill(clr_ill),
        .upc(upc_b), .dispatch_fire(fire_b), .illegal(ill_b), .icount(icnt_b)
    );

    function automatic int target(input logic [6:0] op);
        if (op == 7'b0110011) return 3;
        if (op == 7'b0010011) return 6;
        if (op == 7'b0000011) return 9;
        if (op == 7'b0100011) return 12;
        return 31;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one instruction-level step per clock.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_upc = 0; m_fire = 0; m_ill = 0; m_cnt = 0;
        end else if (stall) begin
            m_fire = 0;
        end else begin
            m_fire = 0;
            if (clr_ill) m_ill = 0;
            if (seq_op == INC) begin
                m_upc = (m_upc + 1) % 32;
            end else if (seq_op == DSP && instr_valid) begin
                m_upc  = target(opcode);
                m_fire = 1;
                if (target(opcode) == 31) m_ill = 1;
            end else if (seq_op == FET) begin
                m_upc = 0;
                m_cnt = (m_cnt + 1) % 65536;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("upc", int'(upc_a), m_upc);
        chk("dispatch_fire", int'(fire_a), int'(m_fire));
        chk("illegal", int'(ill_a), int'(m_ill));
        chk("icount", int'(icnt_a), m_cnt);
        chk("instr_ready", int'(ready_a), int'(seq_op == DSP && !stall));
        chk("upc_cnt4", int'(upc_b), m_upc);
        chk("fire_cnt4", int'(fire_b), int'(m_fire));
        chk("illegal_cnt4", int'(ill_b), int'(m_ill));
        chk("icount_cnt4", int'(icnt_b), m_cnt % 16);
        chk("ready_cnt4", int'(ready_b), int'(seq_op == DSP && !stall));
    end

    // Drive one microword just after an edge, sample ready, return just after the next edge.
    task automatic step(input logic [1:0] s, input logic v, input logic [6:0] op,
                        input logic st, input logic cl);
        seq_op = s; instr_valid = v; opcode = op; stall = st; clr_ill = cl;
        #1 rdy_seen = ready_a;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        seq_op = HLD; instr_valid = 1'b0; stall = 1'b0; clr_ill = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    logic [6:0] legal_ops [4];
    int legal_tgt [4];
    int fires;

    initial begin
        legal_ops[0] = 7'b0110011; legal_tgt[0] = 3;
        legal_ops[1] = 7'b0010011; legal_tgt[1] = 6;
        legal_ops[2] = 7'b0000011; legal_tgt[2] = 9;
        legal_ops[3] = 7'b0100011; legal_tgt[3] = 12;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_upc", int'(upc_a), 0);
        chk("reset_fire", int'(fire_a), 0);
        chk("reset_illegal", int'(ill_a), 0);
        chk("reset_icount", int'(icnt_a), 0);

        // Free-running increment with wrap at 32
        for (int i = 0; i < 40; i++) begin
            step(INC, 1'b0, 7'd0, 1'b0, 1'b0);
            chk("inc_upc", int'(upc_a), (i + 1) % 32);
        end
        chk("inc_icount", int'(icnt_a), 0);

        // Each legal class dispatches to its entry point
        for (int k = 0; k < 4; k++) begin
            step(FET, 1'b0, 7'd0, 1'b0, 1'b0);
            step(DSP, 1'b1, legal_ops[k], 1'b0, 1'b0);
            chk("dsp_ready", int'(rdy_seen), 1);
            chk("dsp_upc", int'(upc_a), legal_tgt[k]);
            chk("dsp_fire", int'(fire_a), 1);
            step(HLD, 1'b0, 7'd0, 1'b0, 1'b0);
            chk("dsp_fire_end", int'(fire_a), 0);
            chk("hold_upc", int'(upc_a), legal_tgt[k]);
        end

        // Waiting for a valid opcode
        step(FET, 1'b0, 7'd0, 1'b0, 1'b0);
        fires = 0;
        for (int i = 0; i < 3; i++) begin
            step(DSP, 1'b0, 7'b0010011, 1'b0, 1'b0);
            chk("wait_ready", int'(rdy_seen), 1);
            chk("wait_upc", int'(upc_a), 0);
            fires += int'(fire_a);
        end
        step(DSP, 1'b1, 7'b0010011, 1'b0, 1'b0);
        chk("wait_upc_disp", int'(upc_a), 6);
        fires += int'(fire_a);
        for (int i = 0; i < 2; i++) begin
            step(HLD, 1'b0, 7'd0, 1'b0, 1'b0);
            fires += int'(fire_a);
        end
        chk("wait_pulses", fires, 1);

        // Illegal opcode trap and sticky flag
        step(FET, 1'b0, 7'd0, 1'b0, 1'b0);
        step(DSP, 1'b1, 7'b1111111, 1'b0, 1'b0);
        chk("ill_upc", int'(upc_a), 31);
        chk("ill_set", int'(ill_a), 1);
        step(FET, 1'b0, 7'd0, 1'b0, 1'b0);
        step(DSP, 1'b1, 7'b0110011, 1'b0, 1'b0);
        chk("ill_sticky", int'(ill_a), 1);
        step(HLD, 1'b0, 7'd0, 1'b0, 1'b1);
        chk("ill_clear", int'(ill_a), 0);
        step(FET, 1'b0, 7'd0, 1'b0, 1'b0);
        step(DSP, 1'b1, 7'b1111111, 1'b0, 1'b1);
        chk("ill_set_wins", int'(ill_a), 1);

        // Retired counter, including the 4-bit wrap
        do_reset();
        for (int i = 0; i < 5; i++) step(FET, 1'b0, 7'd0, 1'b0, 1'b0);
        chk("fetch5_icount", int'(icnt_a), 5);
        chk("fetch5_icount4", int'(icnt_b), 5);
        for (int i = 0; i < 12; i++) step(FET, 1'b0, 7'd0, 1'b0, 1'b0);
        chk("fetch17_icount", int'(icnt_a), 17);
        chk("fetch17_icount4", int'(icnt_b), 1);

        // Stall freezes INC, DISPATCH, FETCH and the flag clear
        step(DSP, 1'b1, 7'b1010101, 1'b0, 1'b0);
        step(INC, 1'b0, 7'd0, 1'b1, 1'b0);
        chk("stall_inc_upc", int'(upc_a), 31);
        step(DSP, 1'b1, 7'b0110011, 1'b1, 1'b0);
        chk("stall_ready", int'(rdy_seen), 0);
        chk("stall_dsp_upc", int'(upc_a), 31);
        chk("stall_dsp_fire", int'(fire_a), 0);
        step(FET, 1'b0, 7'd0, 1'b1, 1'b1);
        chk("stall_fet_icount", int'(icnt_a), 17);
        chk("stall_illegal", int'(ill_a), 1);
        step(INC, 1'b0, 7'd0, 1'b0, 1'b0);
        chk("unstall_wrap", int'(upc_a), 0);

        // Asynchronous reset in mid-sequence
        step(FET, 1'b0, 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(INC, 1'b0, 7'd0, 1'b0, 1'b0);
        chk("pre_reset_upc", int'(upc_a), 7);
        seq_op = DSP; instr_valid = 1'b1; opcode = 7'b0110011;
        reset = 1'b1;
        #1;
        chk("async_reset_upc", int'(upc_a), 0);
        chk("async_reset_icount", int'(icnt_a), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            logic [6:0] op;
            if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 3)];
            else op = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 99) == 0) reset = 1'b1;
            step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), op,
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0));
            reset = 1'b0;
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/useq_dispatch.md
Name: useq_dispatch

Overview:
- Parametrised microprogram sequencer; next generation of the opcode-to-microaddress decoder.
- Owns the uPC register and steps it each cycle under microword control (increment / dispatch / return-to-fetch / hold).
- Dispatches on opcode class: R-ALU, I-ALU, LOAD, STORE, plus an illegal-opcode trap.
- Sits between the instruction register (valid/ready handshake) and the external microcode ROM, which the uPC output addresses.

Parameters:
UPC_W, 5, uPC width; microcode ROM depth 2^UPC_W
CNT_W, 16, width of retired-instruction counter
FETCH_ADDR, 0, uPC target of a FETCH sequence op and reset value
R_ADDR, 3, dispatch target for opcode 7'b0110011
I_ADDR, 6, dispatch target for opcode 7'b0010011
LD_ADDR, 9, dispatch target for opcode 7'b0000011
ST_ADDR, 12, dispatch target for opcode 7'b0100011
ILL_ADDR, 2^UPC_W-1, dispatch target for any other opcode

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
instr_valid  in  1  opcode is valid
instr_ready  out  1  sequencer consumes the opcode this cycle (combinational)
opcode  in  7  instruction opcode field
seq_op  in  2  from current microword: 00 INC, 01 DISPATCH, 10 FETCH, 11 HOLD
stall  in  1  datapath/memory stall; freezes sequencer
clr_ill  in  1  clears sticky illegal flag
upc  out  UPC_W  current microprogram counter (registered)
dispatch_fire  out  1  registered one-cycle pulse after each accepted dispatch
illegal  out  1  sticky flag: an illegal opcode was dispatched
icount  out  CNT_W  retired-instruction count (registered)

Behaviour:
- Reset (async assert, sync release): upc=FETCH_ADDR, dispatch_fire=0, illegal=0, icount=0.
- instr_ready = (seq_op==DISPATCH) & !stall. It does not depend on instr_valid.
- Accept = instr_ready & instr_valid.
- Next uPC, priority order:
  1. stall=1: upc holds; no counter or flag changes; dispatch_fire=0 next cycle.
  2. INC: upc <= upc+1, modulo 2^UPC_W (ILL_ADDR+1 wraps to 0).
  3. DISPATCH with instr_valid=0: upc holds (waits for opcode); no pulse.
  4. DISPATCH with accept: upc <= table[opcode]; dispatch_fire=1 for exactly the next cycle.
  5. FETCH: upc <= FETCH_ADDR; icount <= icount+1, wrapping at 2^CNT_W.
  6. HOLD: upc holds.
- Decode table: 0110011→R_ADDR, 0010011→I_ADDR, 0000011→LD_ADDR, 0100011→ST_ADDR, all others→ILL_ADDR. An illegal dispatch sets illegal=1 on the same edge the upc loads.
- illegal is sticky. clr_ill=1 clears it on the next edge. If an illegal dispatch and clr_ill=1 coincide, set wins (illegal stays 1).
- Latency: every seq_op effect is visible on upc one clock after the edge. Opcode → upc is 1 cycle.
- Reset asserted mid-sequence overrides everything immediately (async); the in-flight opcode is dropped and icount is not incremented.
- All parameter addresses must be < 2^UPC_W. Elaboration fails (assertion) otherwise.

Test Plan:
- Reset release, seq_op=INC for 40 cycles → upc 0,1,...,31,0,... (wrap); icount=0; dispatch_fire=0.
- upc=0, seq_op=DISPATCH, opcode=0110011, instr_valid=1 → instr_ready=1; next cycle upc=3, dispatch_fire=1 for one cycle; repeat with 0010011→6, 0000011→9, 0100011→12.
- DISPATCH with instr_valid=0 for 3 cycles, then valid with opcode=0010011 → upc held at 0 for 3 cycles, then 6; exactly one dispatch_fire pulse.
- opcode=1111111 dispatched → upc=31, illegal=1, stays 1 after further dispatches. clr_ill=1 → illegal=0. Illegal dispatch coincident with clr_ill → illegal=1.
- seq_op=FETCH five times; CNT_W=4 build with 17 FETCHes → icount=5; icount wraps to 1.
- stall=1 during INC, DISPATCH (valid=1) and FETCH → instr_ready=0; upc, icount, illegal unchanged. Reset pulsed mid-sequence at upc=7 → upc=0 and icount=0 immediately, before the next clock edge.
